// File: rtl/codec_cfg_ctrl_pkg.sv
// codec_cfg_ctrl_pkg: sequencer state encoding, default device address and byte selection helper.
package codec_cfg_ctrl_pkg;
    typedef enum logic [2:0] {IDLE, START, BYTE, ACK, STOP, GAP, DONE} state_t;
    localparam logic [7:0] DEV_ADDR_DEF = 8'h34;
    function automatic logic [7:0] pick_byte(input logic [1:0] sel, input logic [7:0] dev, input logic [15:0] word);
        return sel == 2'd0 ? dev : sel == 2'd1 ? word[15:8] : word[7:0];
    endfunction
endpackage

// File: rtl/codec_cfg_ctrl_if.sv
// codec_cfg_ctrl_if: control handshake and I2C pin bundle between the sequencer and its surroundings.
interface codec_cfg_ctrl_if;
    logic start;
    logic sda_i;
    logic scl;
    logic sda_oe;
    logic busy;
    logic done;
    logic err;
    logic [3:0] reg_idx;
    modport master(input start, sda_i, output scl, sda_oe, busy, done, err, reg_idx);
    modport slave(output start, sda_i, input scl, sda_oe, busy, done, err, reg_idx);
endinterface

// File: rtl/codec_cfg_rom.sv
// codec_cfg_rom: fixed codec register table, {reg[6:0], data[8:0]} per entry.
module codec_cfg_rom (
    input  logic [3:0]  idx,
    output logic [15:0] word
);
    always_comb begin
        case (idx)
            4'd0: word = 16'h0E13;
            4'd1: word = 16'h0579;
            4'd2: word = 16'h0C07;
            4'd3: word = 16'h1001;
            4'd4: word = 16'h13FF;
            4'd5: word = 16'h1012;
            4'd6: word = 16'h1E00;
            default: word = 16'h0000;
        endcase
    end
endmodule

// File: rtl/codec_cfg_ctrl.sv
// codec_cfg_ctrl: walks the register table and writes each entry to the codec as a 3-byte I2C write,
// retrying NACKed entries and reporting busy/done/err.
module codec_cfg_ctrl
    import codec_cfg_ctrl_pkg::*;
#(
    parameter int         CLK_DIV   = 125,
    parameter logic [7:0] DEV_ADDR  = DEV_ADDR_DEF,
    parameter int         NUM_REGS  = 7,
    parameter int         MAX_RETRY = 3
) (
    input logic              clk,
    input logic              rst_n,
    codec_cfg_ctrl_if.master bus
);
    localparam int DW = $clog2(CLK_DIV);
    localparam logic [3:0] LAST = 4'(NUM_REGS - 1);
    state_t state, state_nxt;
    logic [DW-1:0] div;
    logic [1:0] q, byte_sel;
    logic [2:0] bit_cnt;
    logic [3:0] retry;
    logic nack, fin, tick, accept, scl_nxt, sda_nxt;
    logic [15:0] word;
    logic [7:0] cur_byte;

    codec_cfg_rom u_rom (.idx(bus.reg_idx), .word(word));

    assign accept   = bus.start && (state == IDLE || state == DONE);
    assign tick     = state != IDLE && state != DONE && div == DW'(CLK_DIV - 1);
    assign cur_byte = pick_byte(byte_sel, DEV_ADDR, word);

    // q counts the quarter of the current slot; every state spends whole 4-tick slots
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            div         <= '0;
            q           <= '0;
            byte_sel    <= '0;
            bit_cnt     <= 3'd7;
            retry       <= '0;
            nack        <= 1'b0;
            fin         <= 1'b0;
            bus.scl     <= 1'b1;
            bus.sda_oe  <= 1'b0;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b0;
            bus.err     <= 1'b0;
            bus.reg_idx <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                div         <= '0;
                q           <= '0;
                byte_sel    <= '0;
                bit_cnt     <= 3'd7;
                retry       <= '0;
                nack        <= 1'b0;
                fin         <= 1'b0;
                bus.busy    <= 1'b1;
                bus.done    <= 1'b0;
                bus.err     <= 1'b0;
                bus.reg_idx <= '0;
            end else begin
                if (state != IDLE && state != DONE)
                    div <= tick ? '0 : div + 1'b1;
                if (tick) begin
                    q          <= q + 2'd1;
                    bus.scl    <= scl_nxt;
                    bus.sda_oe <= sda_nxt;
                    if (state == ACK && q == 2'd2)
                        nack <= bus.sda_i;
                    // bit_cnt wraps 0 -> 7 on its own, ready for the next byte
                    if (q == 2'd3 && state == BYTE)
                        bit_cnt <= bit_cnt - 3'd1;
                    if (q == 2'd3 && state == ACK) begin
                        byte_sel <= byte_sel + 2'd1;
                        if (!nack && byte_sel == 2'd2) begin
                            fin <= bus.reg_idx == LAST;
                            if (bus.reg_idx != LAST) begin
                                bus.reg_idx <= bus.reg_idx + 4'd1;
                                retry       <= '0;
                            end
                        end
                    end
                    if (q == 2'd3 && state == GAP) begin
                        byte_sel <= '0;
                        nack     <= 1'b0;
                        fin      <= 1'b0;
                        if (fin) begin
                            bus.done <= 1'b1;
                            bus.busy <= 1'b0;
                        end else if (nack && retry == 4'(MAX_RETRY)) begin
                            bus.err  <= 1'b1;
                            bus.busy <= 1'b0;
                        end else if (nack)
                            retry <= retry + 4'd1;
                    end
                end
            end
        end
    end

    always_comb begin
        state_nxt = state;
        if (accept)
            state_nxt = START;
        else if (tick && q == 2'd3)
            case (state)
                START:   state_nxt = BYTE;
                BYTE:    state_nxt = bit_cnt == 3'd0 ? ACK : BYTE;
                ACK:     state_nxt = (nack || byte_sel == 2'd2) ? STOP : BYTE;
                STOP:    state_nxt = GAP;
                GAP:     state_nxt = fin ? DONE : (nack && retry == 4'(MAX_RETRY)) ? IDLE : START;
                default: state_nxt = state;
            endcase
    end

    // bus levels to apply at the tick that opens quarter q of the current state
    always_comb begin
        scl_nxt = 1'b1;
        sda_nxt = 1'b0;
        case (state)
            START: begin
                scl_nxt = q != 2'd3;
                sda_nxt = q != 2'd0;
            end
            BYTE: begin
                scl_nxt = q[0] ^ q[1];
                sda_nxt = ~cur_byte[bit_cnt];
            end
            ACK:  scl_nxt = q[0] ^ q[1];
            STOP: begin
                scl_nxt = q != 2'd0;
                sda_nxt = ~q[1];
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_codec_cfg_ctrl.sv
// tb_codec_cfg_ctrl: I2C slave model with scripted NACKs, frame scoreboard, SCL timing checker.
module tb_codec_cfg_ctrl;
    localparam int CLK_DIV   = 2;
    localparam int MAX_RETRY = 3;
    localparam int NUM_REGS  = 7;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic slave_pull = 1'b0;
    logic sda_line;
    int n_tests = 0;
    int n_fail = 0;
    int cond_cnt = 0;

    logic [15:0] tbl [NUM_REGS] = '{16'h0E13, 16'h0579, 16'h0C07, 16'h1001, 16'h13FF, 16'h1012, 16'h1E00};
    int nplan [NUM_REGS];
    int pbyte [NUM_REGS][4];
    int exp_n[$];
    logic [23:0] exp_d[$];
    int slave_plan[$];
    int exp_lat;
    logic exp_done, exp_err;

    codec_cfg_ctrl_if bus();
    codec_cfg_ctrl #(.CLK_DIV(CLK_DIV), .MAX_RETRY(MAX_RETRY), .NUM_REGS(NUM_REGS)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    assign sda_line  = ~(bus.sda_oe | slave_pull);
    assign bus.sda_i = sda_line;

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] byte_of(input int i, input int b);
        return b == 0 ? 8'h34 : b == 1 ? tbl[i][15:8] : tbl[i][7:0];
    endfunction

    task automatic clear_plan();
        for (int i = 0; i < NUM_REGS; i++) nplan[i] = 0;
    endtask

    // expected frames and latency: each attempt costs START+STOP+GAP (12 ticks) plus 36 ticks per byte sent
    task automatic model();
        int ticks;
        bit dead;
        ticks = 0;
        dead = 0;
        exp_done = 1'b1;
        exp_err = 1'b0;
        for (int i = 0; i < NUM_REGS && !dead; i++)
            for (int a = 0; a <= MAX_RETRY; a++) begin
                int k, n;
                logic [23:0] d;
                k = a < nplan[i] ? pbyte[i][a] : 0;
                n = k == 0 ? 3 : k;
                d = '0;
                for (int b = 0; b < n; b++) d = {d[15:0], byte_of(i, b)};
                exp_n.push_back(n);
                exp_d.push_back(d);
                slave_plan.push_back(k);
                ticks += 12 + 36 * n;
                if (k == 0) break;
                if (a == MAX_RETRY) begin
                    dead = 1;
                    exp_done = 1'b0;
                    exp_err = 1'b1;
                end
            end
        exp_lat = ticks * CLK_DIV + 1;
    endtask

    task automatic run(input bit mid);
        int cyc;
        bit pulsed;
        model();
        @(posedge clk); #1 bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
        cyc = 1;
        pulsed = 0;
        check("accept_busy", 32'(bus.busy), 1);
        check("accept_done_clr", 32'(bus.done), 0);
        check("accept_err_clr", 32'(bus.err), 0);
        while (!(bus.done || bus.err) && cyc < exp_lat + 100) begin
            @(posedge clk); #1;
            cyc++;
            bus.start = 1'b0;
            if (mid && !pulsed && bus.reg_idx == 4'd2) begin
                bus.start = 1'b1;
                pulsed = 1;
            end
        end
        bus.start = 1'b0;
        check("latency", 32'(cyc), 32'(exp_lat));
        check("done", 32'(bus.done), 32'(exp_done));
        check("err", 32'(bus.err), 32'(exp_err));
        check("busy_end", 32'(bus.busy), 0);
        check("scl_end", 32'(bus.scl), 1);
        check("sda_oe_end", 32'(bus.sda_oe), 0);
        check("frames_left", 32'(exp_n.size()), 0);
        if (mid) check("mid_pulse_issued", 32'(pulsed), 1);
        repeat (5) @(posedge clk);
    endtask

    // slave + bus decoder + scoreboard monitor
    initial begin
        logic ps, pd, in_frame, ack_phase;
        logic [7:0] sh;
        logic [23:0] frame;
        int nbits, nbytes, cur_k, en;
        logic [23:0] ed;
        ps = 1'b1; pd = 1'b1; in_frame = 1'b0; ack_phase = 1'b0;
        sh = '0; frame = '0; nbits = 0; nbytes = 0; cur_k = 0;
        forever begin
            @(bus.scl or sda_line or rst_n);
            if (!rst_n) begin
                in_frame = 1'b0;
                ack_phase = 1'b0;
                slave_pull = 1'b0;
            end else if (bus.scl && ps && pd && !sda_line) begin
                cond_cnt++;
                check("start_in_frame", 32'(in_frame), 0);
                in_frame = 1'b1; nbits = 0; nbytes = 0; frame = '0; ack_phase = 1'b0;
                cur_k = slave_plan.size() != 0 ? slave_plan.pop_front() : 0;
            end else if (bus.scl && ps && !pd && sda_line) begin
                cond_cnt++;
                if (in_frame) begin
                    en = exp_n.size() != 0 ? exp_n.pop_front() : -1;
                    ed = exp_d.size() != 0 ? exp_d.pop_front() : 24'hFFFFFF;
                    check("frame_len", 32'(nbytes), 32'(en));
                    check("frame_data", 32'(frame), 32'(ed));
                    in_frame = 1'b0;
                end
            end else if (bus.scl && !ps) begin
                if (in_frame && !ack_phase) begin
                    sh = {sh[6:0], sda_line};
                    nbits++;
                end
            end else if (!bus.scl && ps && in_frame) begin
                if (ack_phase) begin
                    ack_phase = 1'b0;
                    #1 slave_pull = 1'b0;
                end else if (nbits == 8) begin
                    frame = {frame[15:0], sh};
                    nbytes++;
                    nbits = 0;
                    ack_phase = 1'b1;
                    #1 slave_pull = cur_k != nbytes;
                end
            end
            ps = bus.scl;
            pd = sda_line;
        end
    end

    // SCL period checker; high periods spanning a START/STOP condition are exempt
    initial begin
        int cnt, cc;
        logic last;
        bit valid;
        cnt = 0; cc = 0; last = 1'b1; valid = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                valid = 0; cnt = 0; last = bus.scl; cc = cond_cnt;
            end else if (bus.scl !== last) begin
                if (valid && (last == 1'b0 || cond_cnt == cc))
                    check(last ? "scl_high_len" : "scl_low_len", 32'(cnt + 1), 32'(2 * CLK_DIV));
                valid = 1; cnt = 0; last = bus.scl; cc = cond_cnt;
            end else
                cnt++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start = 1'b0;
        rst_n = 1'b0;
        clear_plan();
        repeat (3) @(posedge clk);
        #1;
        check("rst_scl", 32'(bus.scl), 1);
        check("rst_sda_oe", 32'(bus.sda_oe), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_done", 32'(bus.done), 0);
        check("rst_err", 32'(bus.err), 0);
        check("rst_reg_idx", 32'(bus.reg_idx), 0);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        run(0);
        clear_plan();
        nplan[3] = 1; pbyte[3][0] = 2;
        run(0);
        clear_plan();
        nplan[0] = 4;
        for (int a = 0; a < 4; a++) pbyte[0][a] = 1;
        run(0);
        check("err_reg_idx", 32'(bus.reg_idx), 0);
        clear_plan();
        run(1);
        run(0);
        @(posedge clk); #1 bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
        repeat (30) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        check("midrst_scl", 32'(bus.scl), 1);
        check("midrst_sda_oe", 32'(bus.sda_oe), 0);
        check("midrst_busy", 32'(bus.busy), 0);
        check("midrst_reg_idx", 32'(bus.reg_idx), 0);
        rst_n = 1'b1;
        exp_n.delete(); exp_d.delete(); slave_plan.delete();
        repeat (4) @(posedge clk);
        run(0);
        for (int r = 0; r < 4; r++) begin
            clear_plan();
            for (int i = 0; i < NUM_REGS; i++) begin
                nplan[i] = int'($urandom_range(0, 2));
                for (int a = 0; a < 4; a++) pbyte[i][a] = int'($urandom_range(1, 3));
            end
            if (r == 3) nplan[$urandom_range(0, NUM_REGS - 1)] = 4;
            run(0);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
